// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential fully connected layer, one input element per clock,
// N_OUT parallel MAC lanes fed from an external synchronous-read weight memory.
module fc_layer_seq #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int N_IN      = 100,
    parameter int N_OUT     = 32,
    parameter int ADDR_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      relu_en,
    input  logic [DATA_W*N_IN-1:0]    input_fc,
    output logic [ADDR_W-1:0]         weight_addr,
    input  logic [DATA_W*N_OUT-1:0]   input_weights,
    output logic [DATA_W*N_OUT-1:0]   output_fc,
    output logic                      busy,
    output logic                      done
);
    localparam int ACC_W = 2*DATA_W + $clog2(N_IN);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_IN-1);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(DATA_W-1)-1);
    localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(2**(DATA_W-1)));
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(2**(FRAC_BITS-1));

    typedef enum logic [1:0] {IDLE, FETCH, MAC, OUT} state_t;
    state_t state, state_n;

    logic [DATA_W*N_IN-1:0]     x_sr;
    logic                       relu_q;
    logic [ADDR_W-1:0]          k;
    logic [ADDR_W-1:0]          addr_inc;
    logic signed [ACC_W-1:0]    acc  [N_OUT];
    logic signed [2*DATA_W-1:0] prod [N_OUT];
    logic signed [ACC_W:0]      rnd  [N_OUT];
    logic [DATA_W-1:0]          sat  [N_OUT];
    logic [DATA_W-1:0]          res  [N_OUT];

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state == IDLE  ? (start ? FETCH : IDLE) :
                  state == FETCH ? MAC :
                  state == MAC   ? (k == LAST ? OUT : MAC) : IDLE;
    end

    assign busy     = state != IDLE;
    assign addr_inc = weight_addr == LAST ? weight_addr : weight_addr + 1'b1;

    // x_sr shifts down one element per MAC step, so the current x is always the low slice
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            prod[j] = (2*DATA_W)'($signed(x_sr[DATA_W-1:0])) *
                      (2*DATA_W)'($signed(input_weights[j*DATA_W +: DATA_W]));
            rnd[j]  = ((ACC_W+1)'(acc[j]) + HALF) >>> FRAC_BITS;
            sat[j]  = rnd[j] > MAXV ? MAXV[DATA_W-1:0] :
                      rnd[j] < MINV ? MINV[DATA_W-1:0] : rnd[j][DATA_W-1:0];
            res[j]  = (relu_q && sat[j][DATA_W-1]) ? '0 : sat[j];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight_addr <= '0;
            output_fc   <= '0;
            done        <= 1'b0;
            x_sr        <= '0;
            relu_q      <= 1'b0;
            k           <= '0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
        end else begin
            done <= state == OUT;
            case (state)
                IDLE: if (start) begin
                    x_sr        <= input_fc;
                    relu_q      <= relu_en;
                    k           <= '0;
                    weight_addr <= '0;
                    for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
                end
                FETCH: weight_addr <= addr_inc;
                MAC: begin
                    weight_addr <= addr_inc;
                    k           <= k + 1'b1;
                    x_sr        <= x_sr >> DATA_W;
                    for (int j = 0; j < N_OUT; j++) acc[j] <= acc[j] + ACC_W'(prod[j]);
                end
                OUT: begin
                    weight_addr <= '0;
                    for (int j = 0; j < N_OUT; j++) output_fc[j*DATA_W +: DATA_W] <= res[j];
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: directed checks of fc_layer_seq, a small 4x2 instance plus a default-size instance.
module tb_fc_layer_seq;
    logic        clk = 1'b0;
    logic        reset, start, relu_en;
    logic [63:0] xin;
    logic [7:0]  addr;
    logic [31:0] wdata, yout;
    logic        busy, done;

    logic           start_b;
    logic           relu_b = 1'b0;
    logic [1599:0]  xin_b = {100{16'h0100}};
    logic [7:0]     addr_b;
    logic [511:0]   wdata_b, yout_b;
    logic           busy_b, done_b;

    logic [31:0] wmem [256];
    logic [7:0]  addrs [8];
    int checks = 0, fails = 0, cyc, cycb, errs, dones;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        wdata   <= wmem[addr];
        wdata_b <= {32{16'h0001}};
    end

    fc_layer_seq #(.DATA_W(16), .FRAC_BITS(8), .N_IN(4), .N_OUT(2), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .input_fc(xin),
        .weight_addr(addr), .input_weights(wdata), .output_fc(yout), .busy(busy), .done(done));

    fc_layer_seq dut_b (
        .clk(clk), .reset(reset), .start(start_b), .relu_en(relu_b), .input_fc(xin_b),
        .weight_addr(addr_b), .input_weights(wdata_b), .output_fc(yout_b), .busy(busy_b), .done(done_b));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_x(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        xin = {d, c, b, a};
    endtask

    task automatic set_w(input logic [15:0] l0, input logic [15:0] l1);
        for (int r = 0; r < 256; r++) wmem[r] = {l1, l0};
    endtask

    // poke 1: change relu_en/input_fc right after acceptance; poke 2: extra start pulse in 2nd MAC cycle
    task automatic run(input int poke);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        addrs[0] = addr;
        if (poke == 1) begin
            relu_en = ~relu_en;
            set_x(16'h0200, 16'h0200, 16'h0200, 16'h0200);
        end
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc < 8) addrs[cyc] = addr;
            if (poke == 2) start = (cyc == 2);
        end
        start = 1'b0;
    endtask

    task automatic count_dones(input int n);
        dones = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_b = 1'b0; relu_en = 1'b0;
        set_x(16'h0, 16'h0, 16'h0, 16'h0);
        set_w(16'h0, 16'h0);
        repeat (2) @(posedge clk); #1;
        chk("rst_out", yout, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", addr, 8'h0);
        chk("rst_out_b", yout_b, 512'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        set_x(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_w(16'h0100, 16'h0100);
        run(0);
        chk("s1_latency", cyc, 6);
        chk("s1_out", yout, {16'h0400, 16'h0400});
        chk("s1_addr_seq", {addrs[0], addrs[1], addrs[2], addrs[3], addrs[4]}, {8'd0, 8'd1, 8'd2, 8'd3, 8'd3});
        chk("s1_busy_at_done", busy, 1'b0);
        @(posedge clk); #1;
        chk("s1_done_pulse", done, 1'b0);
        chk("s1_hold", yout, {16'h0400, 16'h0400});

        set_w(16'hFF00, 16'hFF00);
        run(0);
        chk("s2_neg", yout, {16'hFC00, 16'hFC00});
        relu_en = 1'b1;
        run(0);
        chk("s2_relu", yout, 32'h0);
        relu_en = 1'b0;

        set_x(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        set_w(16'h7FFF, 16'h7FFF);
        run(0);
        chk("s3_pos_sat", yout, {16'h7FFF, 16'h7FFF});
        set_w(16'h8000, 16'h8000);
        run(0);
        chk("s3_neg_sat", yout, {16'h8000, 16'h8000});
        set_w(16'h7FFF, 16'h8000);
        run(0);
        chk("s3_mixed_lanes", yout, {16'h8000, 16'h7FFF});

        set_x(16'h0001, 16'h0, 16'h0, 16'h0);
        set_w(16'h0080, 16'h007F);
        run(0);
        chk("s4_round_half_7f", yout, {16'h0000, 16'h0001});
        set_w(16'hFF80, 16'h0080);
        run(0);
        chk("s4_round_neg_half", yout, {16'h0001, 16'h0000});

        set_x(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        for (int r = 0; r < 256; r++) wmem[r] = {16'h0100, 16'h0900};
        for (int r = 0; r < 4; r++) wmem[r] = {16'h0100, 16'(16'h0100 * (r + 1))};
        run(0);
        chk("row_align", yout, {16'h0A00, 16'h1E00});

        set_x(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_w(16'hFF00, 16'h0100);
        relu_en = 1'b1;
        run(1);
        chk("inputs_latched", yout, {16'h0400, 16'h0000});
        relu_en = 1'b0;

        set_x(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_w(16'h0100, 16'h0100);
        run(2);
        chk("s5_ignore_lat", cyc, 6);
        chk("s5_ignore_out", yout, {16'h0400, 16'h0400});
        count_dones(12);
        chk("s5_single_done", dones, 0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("s5_rst_out", yout, 32'h0);
        chk("s5_rst_busy", busy, 1'b0);
        chk("s5_rst_addr", addr, 8'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        count_dones(12);
        chk("s5_rst_no_done", dones, 0);
        run(0);
        chk("s5_restart_lat", cyc, 6);
        chk("s5_restart_out", yout, {16'h0400, 16'h0400});

        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cycb = 0;
        errs = (addr_b != 8'd0) ? 1 : 0;
        while (!done_b && cycb < 300) begin
            @(posedge clk); #1;
            cycb++;
            if (cycb <= 100 && addr_b != 8'((cycb < 99) ? cycb : 99)) errs++;
        end
        chk("s6_latency", cycb, 102);
        chk("s6_addr_sweep", errs, 0);
        chk("s6_out", yout_b, {32{16'h0064}});
        chk("s6_busy", busy_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
